// File: rtl/puf_reader_pkg.sv
// Shared definitions for the PUF challenge-response reader: FSM states,
// register map, CTRL bit positions and LFSR constants.
package puf_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } puf_state_e;

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_SEED  = 2'd1;
    localparam logic [1:0] ADDR_RESP  = 2'd2;
    localparam logic [1:0] ADDR_COUNT = 2'd3;

    // CTRL write bits and CTRL read bits share positions 0/1 with different meaning.
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_ABORT_BIT = 1;
    localparam int CTRL_BUSY_BIT  = 0;
    localparam int CTRL_DONE_BIT  = 1;

    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    // Galois step, shifting right: x^32 + x^22 + x^2 + x + 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [31:0] seed_guard(input logic [31:0] s);
        return (s == 32'd0) ? DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/puf_crp_reader_if.sv
// Register bus between the management SoC and the PUF reader.
// Handshake: master holds valid with stable addr/wstrb/wdata; slave answers with a
// one-cycle ready, rdata is valid only while ready=1; wstrb==0 means read.
interface puf_crp_reader_if;
    logic        valid;
    logic [1:0]  addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, addr, wstrb, wdata, input ready, rdata);
    modport slave  (input valid, addr, wstrb, wdata, output ready, rdata);
endinterface

// File: rtl/puf_lfsr.sv
// 32-bit Galois LFSR generating PUF challenges; a zero load is replaced by the
// default seed so the register can never lock up at zero.
module puf_lfsr
    import puf_reader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        advance_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_guard(seed_i);
        end else if (advance_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DEFAULT_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/puf_crp_reader.sv
// Drives challenges and reset pulses into a PUF, samples its synchronized response
// bit per challenge and assembles the bits into a readable response word.
module puf_crp_reader
    import puf_reader_pkg::*;
#(
    parameter int BITS          = 32,
    parameter int RESP_BITS     = 32,
    parameter int RST_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    puf_crp_reader_if.slave     bus,
    output logic [BITS-1:0]     challenge_o,
    output logic                puf_reset_o,
    input  logic                response_i,
    output logic                busy_o,
    output logic                done_o,
    output puf_state_e          dbg_state_o
);

    puf_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] resp_q, resp_d;
    logic [5:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] seed_q, seed_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        sync1_q, sync2_q;

    logic        lfsr_load, lfsr_adv;
    logic [31:0] lfsr_state;
    logic [31:0] seed_merge;
    logic [5:0]  count_inc;
    logic        puf_reset;

    logic acc, wr, rd, ctrl_wr, start_req, abort_req;

    assign acc       = bus.valid && !ready_q;
    assign wr        = acc && (bus.wstrb != 4'd0);
    assign rd        = acc && (bus.wstrb == 4'd0);
    assign ctrl_wr   = wr && (bus.addr == ADDR_CTRL) && bus.wstrb[0];
    assign start_req = ctrl_wr && bus.wdata[CTRL_START_BIT];
    assign abort_req = ctrl_wr && bus.wdata[CTRL_ABORT_BIT];
    assign count_inc = 6'(count_q + 6'd1);

    puf_lfsr u_lfsr (
        .clk       (clk),
        .rst_n     (reset_n),
        .load_i    (lfsr_load),
        .seed_i    (seed_q),
        .advance_i (lfsr_adv),
        .state_o   (lfsr_state)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        resp_d     = resp_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = done_q;
        seed_d     = seed_q;
        ready_d    = acc;
        rdata_d    = rdata_q;
        lfsr_load  = 1'b0;
        lfsr_adv   = 1'b0;
        puf_reset  = 1'b1;
        seed_merge = seed_q;

        if (rd) begin
            case (bus.addr)
                ADDR_CTRL:  rdata_d = {30'd0, done_q, busy_q};
                ADDR_SEED:  rdata_d = seed_q;
                ADDR_RESP:  rdata_d = resp_q;
                default:    rdata_d = {26'd0, count_q};
            endcase
        end

        // A run finishing on this edge re-sets done in the FSM below, so it wins.
        if (rd && bus.addr == ADDR_RESP) begin
            done_d = 1'b0;
        end

        if (wr && bus.addr == ADDR_SEED && !busy_q) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) seed_merge[8*b +: 8] = bus.wdata[8*b +: 8];
            end
            seed_d = seed_guard(seed_merge);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_req && !abort_req) begin
                    lfsr_load = 1'b1;
                    resp_d    = 32'd0;
                    count_d   = 6'd0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = ST_RST;
                end
            end
            ST_RST: begin
                if (cnt_q == 8'(RST_CYCLES - 1)) begin
                    cnt_d   = 8'd0;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = 8'(cnt_q + 8'd1);
                end
            end
            ST_SETTLE: begin
                puf_reset = 1'b0;
                if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = 8'd0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = 8'(cnt_q + 8'd1);
                end
            end
            ST_SAMPLE: begin
                puf_reset = 1'b0;
                resp_d    = {resp_q[30:0], sync2_q};
                count_d   = count_inc;
                lfsr_adv  = 1'b1;
                state_d   = (count_inc == 6'(RESP_BITS)) ? ST_DONE : ST_RST;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort freezes the partial result exactly as it stood before this edge.
        if (abort_req) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            cnt_d    = 8'd0;
            resp_d   = resp_q;
            count_d  = count_q;
            lfsr_load = 1'b0;
            lfsr_adv  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            resp_q  <= 32'd0;
            count_q <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            seed_q  <= DEFAULT_SEED;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            seed_q  <= seed_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            sync1_q <= response_i;
            sync2_q <= sync1_q;
        end
    end

    assign bus.ready   = ready_q;
    assign bus.rdata   = rdata_q;
    assign challenge_o = lfsr_state[BITS-1:0];
    assign puf_reset_o = puf_reset;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_puf_crp_reader.sv
// Directed bench for puf_crp_reader: register access, full runs with a tied and a
// challenge-following PUF, abort, ignored restart and asynchronous reset.
module tb_puf_crp_reader;
  import puf_reader_pkg::*;

  localparam int PER_BIT = 7;
  localparam int RUN_LEN = 32 * PER_BIT + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] challenge_o;
  logic        puf_reset_o, busy_o, done_o, response_i;
  puf_state_e  dbg_state;
  logic        tie_val = 1'b0;
  bit          model_en = 1'b0;
  int unsigned cyc = 0;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  bit          rd_q[$];
  string       name_q[$];

  puf_crp_reader_if bus();

  puf_crp_reader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .challenge_o (challenge_o),
    .puf_reset_o (puf_reset_o),
    .response_i  (response_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dbg_state_o (dbg_state)
  );

  // clock / reset support
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign response_i = model_en ? challenge_o[0] : tie_val;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_step(input logic [31:0] s);
    logic [31:0] t;
    t = {1'b0, s[31:1]};
    if (s[0]) t = t ^ 32'h8020_0003;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every ack pops one expected entry
  always @(negedge clk) begin
    if (bus.ready === 1'b1) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack with rdata 0x%08h, expected no ack", bus.rdata);
      end else begin
        bit          r;
        logic [31:0] e;
        string       nm;
        r  = rd_q.pop_front();
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (r) check(nm, bus.rdata, e);
      end
    end
  end

  // driver tasks
  task automatic bus_xfer(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                          input logic [31:0] e, input string nm, output int unsigned ack_cyc);
    int k;
    rd_q.push_back(s == 4'd0);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.addr  = a;
    bus.wstrb = s;
    bus.wdata = d;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (bus.ready !== 1'b1 && k < 10);
    ack_cyc = cyc;
    if (bus.ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout %s: got no ready in %0d cycles, required ready", nm, k);
    end
    bus.valid = 1'b0;
    bus.wstrb = 4'd0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    int unsigned ack;
    bus_xfer(a, 4'd0, 32'd0, e, nm, ack);
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
    int unsigned ack;
    bus_xfer(a, s, d, 32'd0, "write", ack);
  endtask

  // Called right after the start ack: per-cycle expectation of challenge, PUF reset,
  // busy and done over the whole run.
  task automatic run_watch(input logic [31:0] seed);
    logic [31:0] s;
    s = seed;
    check("challenge@0", challenge_o, s);
    check("busy@0", busy_o, 1'b1);
    check("puf_reset@0", puf_reset_o, 1'b1);
    for (int n = 1; n <= RUN_LEN; n++) begin
      @(posedge clk);
      #1;
      if (n % PER_BIT == 0 && n <= RUN_LEN - 1) s = model_step(s);
      check($sformatf("challenge@%0d", n), challenge_o, s);
      check($sformatf("puf_reset@%0d", n), puf_reset_o, (n >= RUN_LEN - 1) || (n % PER_BIT < 2));
      check($sformatf("busy@%0d", n), busy_o, n < RUN_LEN);
      check($sformatf("done@%0d", n), done_o, n == RUN_LEN);
    end
  endtask

  initial begin
    int unsigned e0;
    int unsigned ack;
    logic [31:0] s;
    logic [31:0] exp_resp;

    bus.valid = 1'b0;
    bus.addr  = 2'd0;
    bus.wstrb = 4'd0;
    bus.wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_puf_reset", puf_reset_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_challenge", challenge_o, 32'h1);
    check("rst_ready", bus.ready, 1'b0);
    check("rst_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    rd(ADDR_SEED, 32'h1, "seed_reset");
    rd(ADDR_CTRL, 32'h0, "ctrl_reset");
    rd(ADDR_RESP, 32'h0, "resp_reset");
    rd(ADDR_COUNT, 32'h0, "count_reset");

    wr(ADDR_SEED, 4'hF, 32'h0);
    rd(ADDR_SEED, 32'h1, "seed_zero_guard");
    wr(ADDR_SEED, 4'hF, 32'hA5A5_A5A5);
    rd(ADDR_SEED, 32'hA5A5_A5A5, "seed_full");
    wr(ADDR_SEED, 4'b0010, 32'h0000_3C00);
    rd(ADDR_SEED, 32'hA5A5_3CA5, "seed_byte1");

    // run with the PUF tied high
    tie_val = 1'b1;
    repeat (3) @(posedge clk);
    bus_xfer(ADDR_CTRL, 4'h1, 32'h1, 32'h0, "start_tie1", ack);
    run_watch(32'hA5A5_3CA5);
    rd(ADDR_CTRL, 32'h2, "ctrl_done");
    check("done_after_ctrl_read", done_o, 1'b1);
    rd(ADDR_RESP, 32'hFFFF_FFFF, "resp_tie1");
    check("done_cleared_by_resp", done_o, 1'b0);
    rd(ADDR_COUNT, 32'd32, "count_full");
    rd(ADDR_CTRL, 32'h0, "ctrl_after_clear");

    // PUF answers with challenge bit 0
    tie_val  = 1'b0;
    model_en = 1'b1;
    wr(ADDR_SEED, 4'hF, 32'h1);
    s = 32'h1;
    exp_resp = 32'h0;
    for (int k = 0; k < 32; k++) begin
      exp_resp = {exp_resp[30:0], s[0]};
      s = model_step(s);
    end
    bus_xfer(ADDR_CTRL, 4'h1, 32'h1, 32'h0, "start_model", ack);
    run_watch(32'h1);
    rd(ADDR_RESP, exp_resp, "resp_model");
    rd(ADDR_COUNT, 32'd32, "count_model");

    // abort at bit 10, with an ignored restart and seed write mid-run
    model_en = 1'b0;
    tie_val  = 1'b1;
    bus_xfer(ADDR_CTRL, 4'h1, 32'h1, 32'h0, "start_abort", e0);
    while (cyc < e0 + 30) @(posedge clk);
    wr(ADDR_CTRL, 4'h1, 32'h1);
    wr(ADDR_SEED, 4'hF, 32'h1234_5678);
    while (cyc < e0 + 71) @(posedge clk);
    bus_xfer(ADDR_CTRL, 4'h1, 32'h3, 32'h0, "abort", ack);
    check("abort_busy", busy_o, 1'b0);
    check("abort_done", done_o, 1'b0);
    check("abort_puf_reset", puf_reset_o, 1'b1);
    check("abort_state", dbg_state, ST_IDLE);
    rd(ADDR_COUNT, 32'd10, "count_abort");
    rd(ADDR_RESP, 32'h0000_03FF, "resp_abort");
    rd(ADDR_SEED, 32'h1, "seed_busy_ignored");
    rd(ADDR_CTRL, 32'h0, "ctrl_abort");

    // asynchronous reset during SETTLE
    wr(ADDR_SEED, 4'hF, 32'h0000_BEEF);
    bus_xfer(ADDR_CTRL, 4'h1, 32'h1, 32'h0, "start_reset", e0);
    while (cyc < e0 + 3) @(posedge clk);
    #2;
    check("pre_reset_settle", puf_reset_o, 1'b0);
    reset_n = 1'b0;
    #1;
    check("arst_challenge", challenge_o, 32'h1);
    check("arst_puf_reset", puf_reset_o, 1'b1);
    check("arst_busy", busy_o, 1'b0);
    check("arst_done", done_o, 1'b0);
    check("arst_ready", bus.ready, 1'b0);
    check("arst_rdata", bus.rdata, 32'h0);
    check("arst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    rd(ADDR_SEED, 32'h1, "seed_after_arst");
    rd(ADDR_COUNT, 32'h0, "count_after_arst");
    bus_xfer(ADDR_CTRL, 4'h1, 32'h1, 32'h0, "start_post_reset", ack);
    run_watch(32'h1);
    rd(ADDR_RESP, 32'hFFFF_FFFF, "resp_post_reset");

    repeat (5) @(negedge clk);
    check("pending_expected", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
